// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter.
// Grants the shared address/control bus to one master at a time. Arbitration
// happens only at transfer boundaries: fixed-length and INCR bursts, and
// locked sequences, keep the current owner until they complete. Master 0 is
// the default master when nobody requests.
module ahb_arbiter #(
  parameter int MASTER_DEVICES   = 4,
  parameter int MASTER_IDX_WIDTH = $clog2(MASTER_DEVICES)
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rstn_in,
  input  logic [MASTER_DEVICES-1:0]   master_busreq_in,
  input  logic [MASTER_DEVICES-1:0]   master_lock_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic                        ahb_ready_in,
  output logic [MASTER_DEVICES-1:0]   master_grant_out,
  output logic [MASTER_IDX_WIDTH-1:0] ahb_master_out,
  output logic                        ahb_mastlock_out
);

  localparam logic [1:0] ST_OPEN   = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_INCR = 3'b001;

  logic [1:0]                  state_q, state_d;
  logic [3:0]                  count_q, count_d;
  logic                        incr_q, incr_d;
  logic [MASTER_IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [MASTER_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [MASTER_IDX_WIDTH-1:0] master_q;
  logic                        mastlock_q;

  logic                        owner_req;
  logic                        owner_lock;
  logic                        is_nonseq;
  logic                        is_seq;
  logic                        burst_fixed;
  logic                        burst_incr;
  logic [3:0]                  load_val;
  logic                        arb_en;
  logic                        req_found;
  logic [MASTER_IDX_WIDTH-1:0] req_winner;

  assign owner_req   = master_busreq_in[grant_idx_q];
  assign owner_lock  = master_lock_in[grant_idx_q];
  assign is_nonseq   = (ahb_trans_in == TRANS_NONSEQ);
  assign is_seq      = (ahb_trans_in == TRANS_SEQ);
  // Any HBURST with bit 2 or bit 1 set is a 4/8/16-beat wrap or increment.
  assign burst_fixed = (ahb_burst_in[2:1] != 2'b00);
  assign burst_incr  = (ahb_burst_in == BURST_INCR);

  // Beat counter preload: remaining SEQ beats after the NONSEQ beat.
  always_comb begin
    case (ahb_burst_in[2:1])
      2'b01:   load_val = 4'd3;
      2'b10:   load_val = 4'd7;
      2'b11:   load_val = 4'd15;
      default: load_val = 4'd0;
    endcase
  end

  // Beat counter: load on accepted NONSEQ, count down on accepted SEQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_d = count_q;
    incr_d  = incr_q;
    if (ahb_ready_in) begin
      if (is_nonseq) begin
        count_d = load_val;
        incr_d  = burst_incr;
      end else if (is_seq && (count_q != 4'd0)) begin
        count_d = count_q - 4'd1;
      end
    end
  end

  // Ownership state: lock beats everything, bursts block arbitration.
  always_comb begin
    state_d = state_q;
    if (ahb_ready_in) begin
      if (owner_lock) begin
        state_d = ST_LOCKED;
      end else begin
        case (state_q)
          ST_OPEN: begin
            if (is_nonseq && (burst_fixed || (burst_incr && owner_req)))
              state_d = ST_BURST;
          end
          ST_BURST: begin
            if (incr_q) begin
              if (!owner_req || (ahb_trans_in == TRANS_IDLE))
                state_d = ST_OPEN;
            end else if (is_seq && (count_d == 4'd0)) begin
              state_d = ST_OPEN;
            end
          end
          ST_LOCKED: begin
            // Lock already dropped here; leave only outside a burst beat.
            if (!is_seq && (ahb_trans_in != TRANS_BUSY))
              state_d = ST_OPEN;
          end
          default: state_d = ST_OPEN;
        endcase
      end
    end
  end

  // Round-robin scan starting after the pointer, so the owner comes last.
  always_comb begin
    int cand;
    req_found  = 1'b0;
    req_winner = '0;
    cand       = 0;
    for (int k = 1; k <= MASTER_DEVICES; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= MASTER_DEVICES)
        cand = cand - MASTER_DEVICES;
      if (!req_found && master_busreq_in[MASTER_IDX_WIDTH'(cand)]) begin
        req_found  = 1'b1;
        req_winner = MASTER_IDX_WIDTH'(cand);
      end
    end
  end

  // Arbitrate only when the bus stays open through this cycle.
  assign arb_en = ahb_ready_in && (state_q == ST_OPEN) && (state_d == ST_OPEN);

  // Next grant index and pointer; default master 0 does not move the pointer.
  always_comb begin
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    if (arb_en) begin
      if (req_found) begin
        grant_idx_d = req_winner;
        ptr_d       = req_winner;
      end else begin
        grant_idx_d = '0;
      end
    end
  end

  // All arbiter state; holds completely while ahb_ready_in is low.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q     <= ST_OPEN;
      count_q     <= 4'd0;
      incr_q      <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      master_q    <= '0;
      mastlock_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      count_q     <= count_d;
      incr_q      <= incr_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
      if (ahb_ready_in) begin
        master_q   <= grant_idx_q;
        mastlock_q <= owner_lock;
      end
    end
  end

  // One-hot grant decoded from the registered index, so it is always one-hot.
  always_comb begin
    master_grant_out              = '0;
    master_grant_out[grant_idx_q] = 1'b1;
  end

  assign ahb_master_out   = master_q;
  assign ahb_mastlock_out = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed self-checking bench for ahb_arbiter (4 masters).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;

  logic       clk;
  logic       rst_n;
  logic [3:0] busreq;
  logic [3:0] lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] master;
  logic       mastlock;

  int checks = 0;
  int errors = 0;

  ahb_arbiter #(.MASTER_DEVICES(4)) dut (
    .ahb_clk_in       (clk),
    .ahb_rstn_in      (rst_n),
    .master_busreq_in (busreq),
    .master_lock_in   (lock),
    .ahb_trans_in     (trans),
    .ahb_burst_in     (burst),
    .ahb_ready_in     (ready),
    .master_grant_out (grant),
    .ahb_master_out   (master),
    .ahb_mastlock_out (mastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] m,
                           input logic l);
    check({tag, "_grant"}, 32'(grant), 32'(g));
    check({tag, "_master"}, 32'(master), 32'(m));
    check({tag, "_mastlock"}, 32'(mastlock), 32'(l));
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    busreq = req;
    lock   = lk;
    trans  = tr;
    burst  = bu;
    ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 4'b0001, 2'd0, 1'b0);
    rst_n = 1'b1;

    // Idle bus: default master 0 stays granted.
    tick(); check_out("idle1", 4'b0001, 2'd0, 1'b0);
    tick(); check_out("idle2", 4'b0001, 2'd0, 1'b0);
    tick(); check_out("idle3", 4'b0001, 2'd0, 1'b0);

    // Round robin: masters 1 and 2 issue SINGLE transfers continuously.
    drive(4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1);
    tick(); check_out("rr1", 4'b0010, 2'd0, 1'b0);
    tick(); check_out("rr2", 4'b0100, 2'd1, 1'b0);
    tick(); check_out("rr3", 4'b0010, 2'd2, 1'b0);
    tick(); check_out("rr4", 4'b0100, 2'd1, 1'b0);
    drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("rr_default", 4'b0001, 2'd2, 1'b0);
    tick(); check_out("rr_settle", 4'b0001, 2'd0, 1'b0);

    // INCR4 by master 1 with master 3 waiting.
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("i4_grant", 4'b0010, 2'd0, 1'b0);
    drive(4'b1010, 4'b0000, NONSEQ, INCR4, 1'b1);
    tick(); check_out("i4_nonseq", 4'b0010, 2'd1, 1'b0);
    trans = SEQ;
    tick(); check_out("i4_seq1", 4'b0010, 2'd1, 1'b0);
    tick(); check_out("i4_seq2", 4'b0010, 2'd1, 1'b0);
    tick(); check_out("i4_seq3", 4'b0010, 2'd1, 1'b0);
    drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("i4_handover", 4'b1000, 2'd1, 1'b0);
    tick(); check_out("i4_master3", 4'b1000, 2'd3, 1'b0);

    // INCR8 by master 3 with 3 wait states after beat 3; master 0 waiting.
    drive(4'b1001, 4'b0000, NONSEQ, INCR8, 1'b1);
    tick(); check_out("i8_nonseq", 4'b1000, 2'd3, 1'b0);
    trans = SEQ;
    tick(); check_out("i8_seq1", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_seq2", 4'b1000, 2'd3, 1'b0);
    ready = 1'b0;
    tick(); check_out("i8_wait1", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_wait2", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_wait3", 4'b1000, 2'd3, 1'b0);
    ready = 1'b1;
    tick(); check_out("i8_seq3", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_seq4", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_seq5", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_seq6", 4'b1000, 2'd3, 1'b0);
    tick(); check_out("i8_seq7", 4'b1000, 2'd3, 1'b0);
    drive(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("i8_handover", 4'b0001, 2'd3, 1'b0);
    tick(); check_out("i8_settle", 4'b0001, 2'd0, 1'b0);

    // Locked sequence by master 2 while master 0 keeps requesting.
    drive(4'b0101, 4'b0100, IDLE, SINGLE, 1'b1);
    tick(); check_out("lk_grant", 4'b0100, 2'd0, 1'b0);
    drive(4'b0101, 4'b0100, NONSEQ, SINGLE, 1'b1);
    tick(); check_out("lk_single1", 4'b0100, 2'd2, 1'b1);
    tick(); check_out("lk_single2", 4'b0100, 2'd2, 1'b1);
    drive(4'b0101, 4'b0100, IDLE, SINGLE, 1'b1);
    tick(); check_out("lk_idle", 4'b0100, 2'd2, 1'b1);
    drive(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("lk_release", 4'b0100, 2'd2, 1'b0);
    tick(); check_out("lk_handover", 4'b0001, 2'd2, 1'b0);
    tick(); check_out("lk_settle", 4'b0001, 2'd0, 1'b0);

    // WRAP16 by master 2 interrupted by reset at beat 5.
    drive(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("w16_grant", 4'b0100, 2'd0, 1'b0);
    drive(4'b0101, 4'b0000, NONSEQ, WRAP16, 1'b1);
    tick(); check_out("w16_nonseq", 4'b0100, 2'd2, 1'b0);
    trans = SEQ;
    repeat (4) tick();
    check_out("w16_beat5", 4'b0100, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("w16_async_reset", 4'b0001, 2'd0, 1'b0);
    #2;
    rst_n = 1'b1;

    // Fresh INCR4 after reset: master 1 keeps the bus for 3 SEQ beats.
    drive(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("post_grant", 4'b0010, 2'd0, 1'b0);
    drive(4'b1010, 4'b0000, NONSEQ, INCR4, 1'b1);
    tick(); check_out("post_nonseq", 4'b0010, 2'd1, 1'b0);
    trans = SEQ;
    tick(); check_out("post_seq1", 4'b0010, 2'd1, 1'b0);
    tick(); check_out("post_seq2", 4'b0010, 2'd1, 1'b0);
    tick(); check_out("post_seq3", 4'b0010, 2'd1, 1'b0);
    drive(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
    tick(); check_out("post_handover", 4'b1000, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
